// File: rtl/sample_fifo_if.sv
// Port bundle for sample_fifo: upstream req/ack sample input, strobed sample output and status.
// Vectors are big-endian ([0:N-1]) to match the resampling filter's bus.
interface sample_fifo_if #(
    parameter int DWIDTH    = 16,
    parameter int DEPTH_LOG = 4
);
    logic                in_req;
    logic                in_ack;
    logic [0:DWIDTH-1]   in_data;
    logic                out_strobe;
    logic [0:DWIDTH-1]   out_data;
    logic [0:DEPTH_LOG]  level;
    logic                underrun;
    logic                clr_underrun;
    logic                dbg_run;

    modport master (
        output in_req, in_data, clr_underrun,
        input  in_ack, out_strobe, out_data, level, underrun, dbg_run
    );

    modport slave (
        input  in_req, in_data, clr_underrun,
        output in_ack, out_strobe, out_data, level, underrun, dbg_run
    );
endinterface

// File: rtl/sample_fifo.sv
// Rate-decoupling sample buffer: four-phase req/ack writes into a small FIFO, which is replayed
// one sample every DIV clocks after a prefill threshold; sticky underrun flag on an empty tick.
module sample_fifo #(
    parameter int DWIDTH    = 16,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = 4,
    parameter int DIV       = 32,
    parameter int START     = 8
) (
    input  logic         clk,
    input  logic         rst,
    sample_fifo_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]      TICK_AT = CW'(DIV - 1);
    localparam logic [DEPTH_LOG:0] FULL_L  = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] START_L = (DEPTH_LOG + 1)'(START);

    typedef enum logic {PREFILL = 1'b0, RUN = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DEPTH_LOG-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_LOG:0]     level_q, level_d;
    logic                   ack_q, ack_d;
    logic                   strobe_q, strobe_d;
    logic                   und_q, und_d;
    logic [0:DWIDTH-1]      out_q, out_d;
    logic [0:DWIDTH-1]      mem_q [DEPTH];
    logic                   tick, accept, pop;

    // Handshake: a sample is taken when in_req=1 while in_ack=0 and the FIFO is not full; in_ack
    // then pulses for exactly one cycle, so the upstream must drop in_req before the next capture.
    always_comb begin
        tick     = (cnt_q == TICK_AT);
        accept   = bus.in_req && !ack_q && (level_q < FULL_L);
        pop      = 1'b0;
        state_d  = state_q;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        ack_d    = accept;
        strobe_d = tick;
        out_d    = out_q;
        und_d    = und_q && !bus.clr_underrun;
        rptr_d   = rptr_q;
        wptr_d   = accept ? wptr_q + 1'b1 : wptr_q;

        unique case (state_q)
            PREFILL: begin
                if (tick) out_d = '0;
                if (level_q >= START_L) state_d = RUN;
            end
            RUN: begin
                if (tick) begin
                    if (level_q != '0) begin
                        pop    = 1'b1;
                        out_d  = mem_q[rptr_q];
                        rptr_d = rptr_q + 1'b1;
                    end else begin
                        // Empty on a playback tick: emit silence, flag it, and refill first.
                        out_d   = '0;
                        und_d   = 1'b1;
                        state_d = PREFILL;
                    end
                end
            end
            default: state_d = PREFILL;
        endcase

        unique case ({accept, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= PREFILL;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            ack_q    <= 1'b0;
            strobe_q <= 1'b0;
            und_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
            strobe_q <= strobe_d;
            und_q    <= und_d;
            out_q    <= out_d;
        end
    end

    // Storage is left unreset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wptr_q] <= bus.in_data;
    end

    assign bus.in_ack     = ack_q;
    assign bus.out_strobe = strobe_q;
    assign bus.out_data   = out_q;
    assign bus.level      = level_q;
    assign bus.underrun   = und_q;
    assign bus.dbg_run    = (state_q == RUN);
endmodule
